// File: rtl/acc_ctrl_seq_if.sv
// Instruction and memory-load handshake between the issuing agent and acc_ctrl_seq.
interface acc_ctrl_seq_if;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       mem_req;
    logic       mem_ack;

    modport master (output instr_valid, instr, mem_ack, input instr_ready, mem_req);
    modport slave  (input instr_valid, instr, mem_ack, output instr_ready, mem_req);
endinterface

// File: rtl/acc_ctrl_seq.sv
// Instruction sequencer for the 8-bit accumulator: decodes one instruction per
// accept and drives accumulator strobes, register-file port, ALU op and memory load.
module acc_ctrl_seq #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               Reset,
    acc_ctrl_seq_if.slave      bus,
    output logic               Write_En,
    output logic               From_Reg,
    output logic               From_ALU,
    output logic               From_Imm,
    output logic               Load_Hi,
    output logic [W/2-1:0]     Imm_out,
    output logic [3:0]         reg_addr,
    output logic               reg_we,
    output logic [1:0]         alu_op,
    output logic               reg_in_sel,
    output logic               halted,
    output logic               mem_err
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IMM_W = W / 2;

    localparam logic [2:0] OP_LIL  = 3'b000;
    localparam logic [2:0] OP_LIH  = 3'b001;
    localparam logic [2:0] OP_MOVA = 3'b010;
    localparam logic [2:0] OP_MOVR = 3'b011;
    localparam logic [2:0] OP_ALU  = 3'b100;
    localparam logic [2:0] OP_LDM  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       instr_q, instr_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    logic [2:0] op;
    logic [1:0] sub;
    logic [3:0] fld;

    assign op  = instr_q[8:6];
    assign sub = instr_q[5:4];
    assign fld = instr_q[3:0];

    // State and context registers
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        instr_q  <= instr_d;
        wait_q   <= wait_d;
        halted_q <= halted_d;
        err_q    <= err_d;
    end

    // Next state; Reset overrides accept and mem_ack
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        wait_d   = wait_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_d = '0;
                if (op == OP_LDM) begin
                    state_d = S_MEM_WAIT;
                end else if (op == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = S_IDLE;
                    wait_d  = '0;
                end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                    // TIMEOUT cycles without ack: abort the load
                    state_d = S_IDLE;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: state_d = S_HALT;
        endcase
        if (Reset) begin
            state_d  = S_IDLE;
            instr_d  = '0;
            wait_d   = '0;
            halted_d = 1'b0;
            err_d    = 1'b0;
        end
    end

    // Output decode from state and latched instruction; all zero during Reset
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.mem_req     = 1'b0;
        Write_En        = 1'b0;
        From_Reg        = 1'b0;
        From_ALU        = 1'b0;
        From_Imm        = 1'b0;
        Load_Hi         = 1'b0;
        Imm_out         = '0;
        reg_addr        = '0;
        reg_we          = 1'b0;
        alu_op          = '0;
        reg_in_sel      = 1'b0;
        halted          = 1'b0;
        mem_err         = 1'b0;
        if (!Reset) begin
            halted  = halted_q;
            mem_err = err_q;
            case (state_q)
                S_IDLE: bus.instr_ready = 1'b1;
                S_EXEC: begin
                    case (op)
                        OP_LIL, OP_LIH: begin
                            Write_En = 1'b1;
                            From_Imm = 1'b1;
                            Imm_out  = IMM_W'(fld);
                            Load_Hi  = (op == OP_LIH);
                        end
                        OP_MOVA: begin
                            Write_En = 1'b1;
                            From_Reg = 1'b1;
                            reg_addr = fld;
                        end
                        OP_MOVR: begin
                            reg_we   = 1'b1;
                            reg_addr = fld;
                        end
                        OP_ALU: begin
                            Write_En = 1'b1;
                            From_ALU = 1'b1;
                            alu_op   = sub;
                            reg_addr = fld;
                        end
                        OP_LDM: begin
                            bus.mem_req = 1'b1;
                            reg_addr    = fld;
                        end
                        OP_CLR:  Write_En = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM_WAIT: begin
                    reg_addr = fld;
                    if (bus.mem_ack) begin
                        Write_En   = 1'b1;
                        From_Reg   = 1'b1;
                        reg_in_sel = 1'b1;
                    end else begin
                        bus.mem_req = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
